// File: rtl/gshare_pkg.sv
// Shared types and index/counter helpers for the gshare predictor.
// Pure package: no state, no latency, no flow control.
package gshare_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Widest PC/history the helper functions accept; callers zero-extend to this.
  localparam int MAX_W = 64;

  function automatic logic [31:0] ctr_init_val(input int ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // XOR of consecutive idx_w-bit slices of hist, starting at bit 0.
  function automatic logic [31:0] fold_hist(input logic [MAX_W-1:0] hist,
                                            input int hist_w,
                                            input int idx_w);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < hist_w) res = res ^ (32'(hist[i]) << (i % idx_w));
    end
    return res;
  endfunction

  function automatic logic [31:0] pht_index(input logic [MAX_W-1:0] pc,
                                            input logic [MAX_W-1:0] hist,
                                            input int hist_w,
                                            input int idx_w);
    logic [31:0] res;
    res = fold_hist(hist, hist_w, idx_w);
    for (int i = 0; i < 32; i++) begin
      if (i < idx_w) res = res ^ (32'(pc[i]) << i);
    end
    return res;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table of saturating counters, with init-sweep and training write ports.
// Read is combinational; writes land on the next rising edge; no backpressure.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int IDX_W = 7,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_msb
);

  localparam int              DEPTH   = 1 << IDX_W;
  localparam logic [31:0]     INIT32  = ctr_init_val(CTR_W);
  localparam logic [CTR_W-1:0] INIT_V = INIT32[CTR_W-1:0];
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  // No reset on the array: the init sweep restores every entry after reset.
  logic [CTR_W-1:0] mem [DEPTH];
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_nxt;

  assign rd_msb  = mem[rd_idx][CTR_W-1];
  assign upd_cur = mem[upd_idx];

  always_comb begin
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + CTR_ONE;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - CTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (init_en) mem[init_idx] <= INIT_V;
    else if (upd_en) mem[upd_idx] <= upd_nxt;
  end

endmodule

// File: rtl/gshare_param.sv
// Gshare branch predictor: init FSM, global history register and PHT lookup/training.
// Prediction is combinational; ready stays low for 2^IDX_W cycles after reset while the PHT is swept.
module gshare_param
  import gshare_pkg::*;
#(
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int IDX_W  = 7,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              areset,
  output logic              ready,
  input  logic              predict_valid,
  input  logic [PC_W-1:0]   predict_pc,
  output logic              predict_taken,
  output logic [HIST_W-1:0] predict_history,
  input  logic              train_valid,
  input  logic              train_taken,
  input  logic              train_mispredicted,
  input  logic [HIST_W-1:0] train_history,
  input  logic [PC_W-1:0]   train_pc
);

  generate
    if (PC_W < IDX_W || HIST_W < 1 || IDX_W < 1 || CTR_W < 1 ||
        PC_W > MAX_W || HIST_W > MAX_W || IDX_W > 30 || CTR_W > 32) begin : g_bad_params
      $error("gshare_param: illegal parameter combination");
    end
  endgenerate

  localparam logic [IDX_W-1:0] PTR_LAST = '1;

  state_e            state;
  state_e            state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] ghr_nxt;
  logic [HIST_W-1:0] ghr_train;
  logic [HIST_W-1:0] ghr_pred;
  logic              init_en;
  logic              upd_en;
  logic              pht_msb;
  logic [31:0]       pred_idx32;
  logic [31:0]       train_idx32;
  logic              unused_idx_bits;

  assign pred_idx32  = pht_index(MAX_W'(predict_pc), MAX_W'(ghr), HIST_W, IDX_W);
  assign train_idx32 = pht_index(MAX_W'(train_pc), MAX_W'(train_history), HIST_W, IDX_W);
  assign unused_idx_bits = ^{pred_idx32[31:IDX_W], train_idx32[31:IDX_W]};

  generate
    if (HIST_W == 1) begin : g_hist1
      assign ghr_train = train_taken;
      assign ghr_pred  = predict_taken;
    end else begin : g_histn
      assign ghr_train = {train_history[HIST_W-2:0], train_taken};
      assign ghr_pred  = {ghr[HIST_W-2:0], predict_taken};
    end
  endgenerate

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= ST_INIT;
      ptr   <= '0;
      ghr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      ghr   <= ghr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ghr_nxt   = ghr;
    case (state)
      ST_INIT: begin
        ptr_nxt = ptr + IDX_W'(1);
        if (ptr == PTR_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A mispredict repairs history from the training copy and wins over speculation.
        if (train_valid && train_mispredicted) ghr_nxt = ghr_train;
        else if (predict_valid) ghr_nxt = ghr_pred;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    ready   = (state == ST_RUN);
    init_en = (state == ST_INIT);
    upd_en  = ready && train_valid;
  end

  assign predict_taken   = ready && pht_msb;
  assign predict_history = ghr;

  gshare_pht #(
    .IDX_W(IDX_W),
    .CTR_W(CTR_W)
  ) u_pht (
    .clk      (clk),
    .init_en  (init_en),
    .init_idx (ptr),
    .upd_en   (upd_en),
    .upd_idx  (train_idx32[IDX_W-1:0]),
    .upd_taken(train_taken),
    .rd_idx   (pred_idx32[IDX_W-1:0]),
    .rd_msb   (pht_msb)
  );

endmodule

// File: doc/gshare_param.md
GSHARE_PARAM -- requirements
Module: gshare_param

Interface
REQ-001 SHALL provide parameter: PC_W, 7, predict/train PC width.
REQ-002 SHALL provide parameter: HIST_W, 7, global history register (GHR) width.
REQ-003 SHALL provide parameter: IDX_W, 7, PHT index width; PHT depth = 2^IDX_W.
REQ-004 SHALL provide parameter: CTR_W, 2, saturating counter width.
REQ-005 SHALL use one clock and an asynchronous active-high reset, ports listed first:
- clk  input  1  sole clock; all state updates on rising edge
- areset  input  1  asynchronous, active-high reset
- ready  output  1  high when PHT initialised and inputs are accepted
- predict_valid  input  1  prediction request
- predict_pc  input  PC_W  PC of branch being predicted
- predict_taken  output  1  predicted direction
- predict_history  output  HIST_W  current GHR, to be returned with training
- train_valid  input  1  training request
- train_taken  input  1  resolved direction
- train_mispredicted  input  1  resolved prediction was wrong
- train_history  input  HIST_W  GHR value captured at prediction time
- train_pc  input  PC_W  PC of trained branch

Function
REQ-006 Index SHALL be pc[IDX_W-1:0] XOR fold(history); fold = XOR of consecutive IDX_W-bit slices of history from bit 0, top slice zero-padded; HIST_W<=IDX_W gives zero-extended history.
REQ-007 Elaboration SHALL fail if PC_W<IDX_W, HIST_W<1, IDX_W<1 or CTR_W<1.
REQ-008 Counter init value SHALL be 2^(CTR_W-1)-1 (weakly not-taken; 2'b01 at default).
REQ-009 predict_taken SHALL be combinational: MSB of PHT[index(predict_pc, GHR)] when ready=1, else 0.
REQ-010 predict_history SHALL equal GHR combinationally.
REQ-011 FSM states SHALL be INIT and RUN; INIT writes init value to PHT[ptr] each cycle, ptr increments; after write of ptr=2^IDX_W-1, next state RUN; ready = (state==RUN).
REQ-012 ready SHALL rise exactly 2^IDX_W clock edges after areset deassertion.
REQ-013 While ready=0 all predict/train inputs SHALL be ignored; GHR and PHT change only via init sweep.
REQ-014 In RUN, train_valid SHALL update PHT[index(train_pc, train_history)]: +1 if taken, -1 if not, saturating at 2^CTR_W-1 and 0.
REQ-015 In RUN, GHR update priority: train_valid&&train_mispredicted -> {train_history[HIST_W-2:0], train_taken}; else predict_valid -> {GHR[HIST_W-2:0], predict_taken}; else hold. HIST_W=1 shifts in the single bit only.
REQ-016 Training without mispredict SHALL NOT modify GHR.
REQ-017 Same-cycle train and predict on the same index: predict_taken SHALL reflect the pre-update counter; updated value visible next cycle.
REQ-018 No output SHALL be X after reset regardless of input X during ready=0.

Reset
REQ-019 areset SHALL immediately force GHR=0, state=INIT, ptr=0, ready=0, predict_taken=0.
REQ-020 PHT storage SHALL NOT be reset directly; the INIT sweep SHALL restore every entry.
REQ-021 areset asserted mid-sweep or mid-RUN SHALL restart the sweep from ptr=0.

Structure
REQ-022 Package gshare_pkg SHALL hold the state enum, counter-init constant function and the fold/index function.
REQ-023 PHT storage, saturating update and sweep write port SHALL reside in sub-module gshare_pht; FSM and GHR in gshare_param.

Verification
REQ-024 Defaults: release areset -> ready=0 for 128 cycles, ready=1 on 128th edge; predict_history=0, predict_taken=0 for all 128 PCs.
REQ-025 pc=3, hist=0: two trains taken -> counter 01->10->11, predict_taken=1; third taken stays 11; four not-taken -> 00, predict_taken=0.
REQ-026 GHR=0000101, predict_valid=1 and train mispredicted history=0010000 taken=1 same cycle -> GHR=0100001.
REQ-027 Same-cycle predict and train taken to an 01 entry -> predict_taken=0 that cycle, 1 if re-predicted next cycle after second taken train.
REQ-028 HIST_W=12, IDX_W=7: pc=0, history=12'hF81 -> index 30 (1 XOR 31); train taken twice, predict reads entry 30 as taken.
REQ-029 Assert areset during RUN after training entry 3 to 11 -> ready drops immediately, GHR=0, after 128 cycles entry 3 predicts 0 (counter 01).
